// File: rtl/multiplier_datapath.sv
// -----------------------------------------------------------------------------
// multiplier_datapath
//
// Purpose:
//   Shift-and-add unsigned multiplier datapath. An external controller loads
//   the operands, then issues one step per cycle, choosing add_shift when
//   multiplier_lsb is 1 and shift when it is 0. After WIDTH steps the
//   accumulator holds word1*word2 and product_valid rises one cycle later.
//
// Parameters:
//   WIDTH          operand width in bits (2..32)
//
// Ports:
//   clk            rising-edge clock for all state
//   reset_n        asynchronous, active-low reset
//   word1          multiplicand operand (unsigned)
//   word2          multiplier operand (unsigned)
//   load_words     capture operands, clear accumulator, counter and valid
//   shift          shift-only step (multiplier bit 0)
//   add_shift      add-then-shift step (multiplier bit 1)
//   multiplier_lsb bit 0 of the multiplier register
//   count_check    multiplication finished
//   product        accumulator contents
//   product_valid  product holds a completed result
//
// Configuration macro:
//   EARLY_EXIT_EN  when defined, the operation also counts as finished once
//                  the remaining multiplier bits are all zero, and further
//                  steps are ignored. The product is still exact because
//                  those remaining steps could only have been shifts.
// -----------------------------------------------------------------------------
module multiplier_datapath #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [WIDTH-1:0]   word1,
  input  logic [WIDTH-1:0]   word2,
  input  logic               load_words,
  input  logic               shift,
  input  logic               add_shift,
  output logic               multiplier_lsb,
  output logic               count_check,
  output logic [2*WIDTH-1:0] product,
  output logic               product_valid
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  logic [2*WIDTH-1:0] m_reg;
  logic [WIDTH-1:0]   q_reg;
  logic [2*WIDTH-1:0] p_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               vld_reg;
  logic               loaded;

  logic               cnt_done;
  logic               step_en;

  // The counter saturates at WIDTH; that alone marks completion in the
  // default build.
  assign cnt_done = (cnt_reg == CNT_MAX);

`ifdef EARLY_EXIT_EN
  // Once the multiplier register has shifted down to zero, every remaining
  // step would be a plain shift that never touches the accumulator, so the
  // result is already final. The loaded flag keeps the all-zero registers
  // left behind by reset from looking like a finished operation.
  assign count_check = cnt_done || (loaded && (q_reg == '0));
`else
  assign count_check = cnt_done;
`endif

  // A step only happens for an operation that was actually loaded and has not
  // finished yet. add_shift wins over shift, so either request starts a step.
  assign step_en = loaded && !count_check && (shift || add_shift);

  // Operand, accumulator and counter registers. Load has top priority and
  // rebuilds every register, which is also what makes a mid-operation load
  // an abort with no leftovers from the old operands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_reg   <= '0;
      q_reg   <= '0;
      p_reg   <= '0;
      cnt_reg <= '0;
    end else if (load_words) begin
      m_reg   <= {{WIDTH{1'b0}}, word1};
      q_reg   <= word2;
      p_reg   <= '0;
      cnt_reg <= '0;
    end else if (step_en) begin
      if (add_shift) begin
        p_reg <= p_reg + m_reg;
      end
      m_reg   <= m_reg << 1;
      q_reg   <= q_reg >> 1;
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  // Valid flag: registered one edge after completion is seen, and sticky until
  // the next load or reset so saturated steps cannot clear it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_reg <= 1'b0;
    end else if (load_words) begin
      vld_reg <= 1'b0;
    end else if (count_check) begin
      vld_reg <= 1'b1;
    end
  end

  // Remembers that operands have been captured since reset, so stray step
  // pulses after a reset are ignored until a fresh load arrives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      loaded <= 1'b0;
    end else if (load_words) begin
      loaded <= 1'b1;
    end
  end

  // All visible results come straight from registers.
  assign multiplier_lsb = q_reg[0];
  assign product        = p_reg;
  assign product_valid  = vld_reg;

endmodule

// File: tb/tb_multiplier_datapath.sv
// -----------------------------------------------------------------------------
// tb_multiplier_datapath
//
// Purpose:
//   Self-checking bench for multiplier_datapath (WIDTH=8). A stimulus process
//   drives loads and steps, pushing the arithmetic product of each operation
//   that will complete into a queue; a monitor pops that queue whenever
//   product_valid rises and compares. Directed checks cover reset, latency,
//   maximum operands, saturation, priority, abort and asynchronous reset.
//   Honours EARLY_EXIT_EN when computing the expected step count.
// -----------------------------------------------------------------------------
module tb_multiplier_datapath;

  localparam int W = 8;

  logic           clk;
  logic           reset_n;
  logic [W-1:0]   word1;
  logic [W-1:0]   word2;
  logic           load_words;
  logic           shift;
  logic           add_shift;
  logic           multiplier_lsb;
  logic           count_check;
  logic [2*W-1:0] product;
  logic           product_valid;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];

  multiplier_datapath #(.WIDTH(W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .word1          (word1),
    .word2          (word2),
    .load_words     (load_words),
    .shift          (shift),
    .add_shift      (add_shift),
    .multiplier_lsb (multiplier_lsb),
    .count_check    (count_check),
    .product        (product),
    .product_valid  (product_valid)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: every check steps the counters used in the
  // summary line.
  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference model: number of steps until count_check, from the rules alone.
  function automatic int steps_needed(input logic [W-1:0] b);
    int n;
`ifdef EARLY_EXIT_EN
    n = 0;
    while (b != '0) begin
      b = b >> 1;
      n++;
    end
`else
    n = W;
`endif
    return n;
  endfunction

  // Drive one cycle of control inputs from the falling edge; returns at the
  // next falling edge with controls released, so outputs show that edge.
  task automatic apply_stimulus(input logic lw, input logic sh, input logic as,
                                input logic [W-1:0] a, input logic [W-1:0] b);
    load_words = lw;
    shift      = sh;
    add_shift  = as;
    word1      = a;
    word2      = b;
    @(negedge clk);
    load_words = 1'b0;
    shift      = 1'b0;
    add_shift  = 1'b0;
  endtask

  // One step chosen by multiplier_lsb, with optional idle cycle before it and
  // optionally both step inputs high on a 1-bit (add_shift must win).
  task automatic do_step(input bit randomize_it);
    logic both;
    if (randomize_it && $urandom_range(0, 3) == 0)
      apply_stimulus(1'b0, 1'b0, 1'b0, word1, word2);
    both = randomize_it && ($urandom_range(0, 1) == 1);
    if (multiplier_lsb)
      apply_stimulus(1'b0, both, 1'b1, word1, word2);
    else
      apply_stimulus(1'b0, 1'b1, 1'b0, word1, word2);
  endtask

  // Load operands; when push is set the expected product enters the scoreboard.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit push, input logic with_add);
    if (push) exp_q.push_back((2*W)'(a) * (2*W)'(b));
    apply_stimulus(1'b1, 1'b0, with_add, a, b);
    check_output("load clears product", 64'(product), 64'(0));
    check_output("load clears valid", 64'(product_valid), 64'(0));
  endtask

  // Step until completion (bounded), then check count, product and latency.
  task automatic finish_op(input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit randomize_it);
    int n;
    n = 0;
    while (!count_check && n < W + 2) begin
      do_step(randomize_it);
      n++;
    end
    check_output("steps to count_check", 64'(n), 64'(steps_needed(b)));
    check_output("final product", 64'(product), 64'((2*W)'(a) * (2*W)'(b)));
    check_output("valid low at completion", 64'(product_valid), 64'(0));
    apply_stimulus(1'b0, 1'b0, 1'b0, word1, word2);
    check_output("valid one cycle later", 64'(product_valid), 64'(1));
  endtask

  // Monitor: compare against the scoreboard whenever product_valid rises.
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (product_valid && !prev) begin
        if (exp_q.size() == 0)
          check_output("unexpected product_valid", 64'(1), 64'(0));
        else
          check_output("scoreboard product", 64'(product), 64'(exp_q.pop_front()));
      end
      prev = product_valid;
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  // Main stimulus sequence.
  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2*W-1:0] held;
    int k;

    reset_n    = 1'b0;
    word1      = '0;
    word2      = '0;
    load_words = 1'b0;
    shift      = 1'b0;
    add_shift  = 1'b0;

    // Reset state while reset is held.
    #12;
    check_output("reset multiplier_lsb", 64'(multiplier_lsb), 64'(0));
    check_output("reset count_check", 64'(count_check), 64'(0));
    check_output("reset product", 64'(product), 64'(0));
    check_output("reset product_valid", 64'(product_valid), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // 13 * 11 = 143.
    start_op(8'd13, 8'd11, 1'b1, 1'b0);
    finish_op(8'd13, 8'd11, 1'b0);

    // Maximum operands.
    start_op(8'd255, 8'd255, 1'b1, 1'b0);
    finish_op(8'd255, 8'd255, 1'b0);

    // Small multiplier: early exit or full run depending on build.
    start_op(8'd3, 8'd1, 1'b1, 1'b0);
    finish_op(8'd3, 8'd1, 1'b0);

    // Saturation: steps after completion change nothing.
    held = product;
    apply_stimulus(1'b0, 1'b1, 1'b0, word1, word2);
    apply_stimulus(1'b0, 1'b0, 1'b1, word1, word2);
    apply_stimulus(1'b0, 1'b1, 1'b1, word1, word2);
    check_output("saturated product", 64'(product), 64'(held));
    check_output("saturated count_check", 64'(count_check), 64'(1));
    check_output("saturated valid", 64'(product_valid), 64'(1));

    // Load together with add_shift: the load wins.
    start_op(8'd9, 8'd10, 1'b1, 1'b1);
    check_output("load priority lsb", 64'(multiplier_lsb), 64'(0));
    finish_op(8'd9, 8'd10, 1'b0);

    // Abort: 200*7 for three steps, then restart with 5*6.
    start_op(8'd200, 8'd7, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) do_step(1'b0);
    check_output("aborted op not valid", 64'(product_valid), 64'(0));
    start_op(8'd5, 8'd6, 1'b1, 1'b0);
    finish_op(8'd5, 8'd6, 1'b0);

    // Asynchronous reset in the middle of an operation, away from any edge.
    start_op(8'd100, 8'd77, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) do_step(1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("async reset product", 64'(product), 64'(0));
    check_output("async reset valid", 64'(product_valid), 64'(0));
    check_output("async reset lsb", 64'(multiplier_lsb), 64'(0));
    check_output("async reset count_check", 64'(count_check), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    // Steps without a fresh load must not produce anything.
    apply_stimulus(1'b0, 1'b0, 1'b1, 8'd50, 8'd50);
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'd50, 8'd50);
    check_output("no action before load product", 64'(product), 64'(0));
    check_output("no action before load valid", 64'(product_valid), 64'(0));

    // Randomized operations with idle cycles, doubled step inputs and aborts.
    for (int t = 0; t < 40; t++) begin
      a = W'($urandom);
      b = W'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        start_op(a, b, 1'b0, 1'b0);
        k = $urandom_range(0, W - 1);
        for (int i = 0; i < k; i++) begin
          if (!count_check) do_step(1'b1);
        end
        a = W'($urandom);
        b = W'($urandom);
      end
      start_op(a, b, 1'b1, 1'b0);
      finish_op(a, b, 1'b1);
      if ($urandom_range(0, 1) == 1)
        apply_stimulus(1'b0, 1'b0, 1'b0, word1, word2);
    end

    // Every expected result must have been matched by a valid output.
    apply_stimulus(1'b0, 1'b0, 1'b0, word1, word2);
    check_output("scoreboard drained", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
